// File: rtl/number_overlay.sv
// Decimal seven-segment overlay: a double-dabble converter feeds a frame-synchronised
// display register, and a 2-stage pixel pipeline draws the digits at (x_in, y_in).
module number_overlay #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned VALUE_W    = 14,
    parameter int unsigned DIGIT_W    = 32,
    parameter int unsigned DIGIT_H    = 48,
    parameter int unsigned GAP        = 8,
    parameter int unsigned SEG_T      = 3,
    parameter logic [23:0] COLOR      = 24'hFFFFFF,
    parameter bit          BLANK_LZ   = 1'b1
) (
    input  logic               pixel_clk_in,
    input  logic               rst_in,
    input  logic [10:0]        x_in,
    input  logic [9:0]         y_in,
    input  logic [10:0]        hcount_in,
    input  logic [9:0]         vcount_in,
    input  logic [VALUE_W-1:0] value_in,
    input  logic               value_valid_in,
    input  logic               frame_start_in,
    output logic [7:0]         red_out,
    output logic [7:0]         green_out,
    output logic [7:0]         blue_out,
    output logic               busy_out,
    output logic               overflow_out
);

    localparam int unsigned PITCH      = DIGIT_W + GAP;
    localparam int unsigned SPAN       = NUM_DIGITS * PITCH;
    // Enough BCD digits for the widest input, so overflow is visible in the upper digits.
    localparam int unsigned VAL_DIGITS = (VALUE_W * 30103) / 100000 + 1;
    localparam int unsigned BCD_N      = (VAL_DIGITS > NUM_DIGITS) ? VAL_DIGITS : NUM_DIGITS;
    localparam int unsigned CNT_W      = $clog2(VALUE_W + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e                  state_q, state_d;
    logic [VALUE_W-1:0]      bin_q, bin_d;
    logic [4*BCD_N-1:0]      bcd_q, bcd_d, bcd_shifted;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [VALUE_W-1:0]      hold_q, hold_d;
    logic                    hold_valid_q, hold_valid_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d, disp_q, disp_d;
    logic                    pend_ovf_q, pend_ovf_d, pend_valid_q, pend_valid_d;
    logic                    disp_ovf_q, disp_ovf_d;
    logic                    bcd_ovf;
    logic [3:0]              nib;
    logic                    carry;

    generate
        if (BCD_N > NUM_DIGITS) begin : g_ovf
            assign bcd_ovf = |bcd_q[4*BCD_N-1:4*NUM_DIGITS];
        end else begin : g_no_ovf
            assign bcd_ovf = 1'b0;
        end
    endgenerate

    // Add-3 correction on every digit, then shift one binary bit in at the bottom.
    always_comb begin
        bcd_shifted = '0;
        nib         = '0;
        carry       = bin_q[VALUE_W-1];
        for (int i = 0; i < BCD_N; i++) begin
            nib = bcd_q[4*i +: 4];
            if (nib >= 4'd5) nib = nib + 4'd3;
            bcd_shifted[4*i +: 4] = {nib[2:0], carry};
            carry = nib[3];
        end
    end

    always_comb begin
        state_d      = state_q;
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        cnt_d        = cnt_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        pend_d       = pend_q;
        pend_ovf_d   = pend_ovf_q;
        pend_valid_d = pend_valid_q;
        disp_d       = disp_q;
        disp_ovf_d   = disp_ovf_q;

        if (frame_start_in && pend_valid_q) begin
            disp_d       = pend_q;
            disp_ovf_d   = pend_ovf_q;
            pend_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (hold_valid_q || value_valid_in) begin
                    bin_d   = hold_valid_q ? hold_q : value_in;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
                // A strobe landing on the cycle a held value launches becomes the new hold.
                if (hold_valid_q) begin
                    hold_valid_d = value_valid_in;
                    if (value_valid_in) hold_d = value_in;
                end
            end
            StShift: begin
                bcd_d = bcd_shifted;
                bin_d = {bin_q[VALUE_W-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(VALUE_W - 1)) state_d = StDone;
            end
            StDone: begin
                pend_d       = bcd_q[4*NUM_DIGITS-1:0];
                pend_ovf_d   = bcd_ovf;
                pend_valid_d = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle && value_valid_in) begin
            hold_d       = value_in;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q      <= StIdle;
            bin_q        <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            pend_q       <= '0;
            pend_ovf_q   <= 1'b0;
            pend_valid_q <= 1'b0;
            disp_q       <= '0;
            disp_ovf_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            pend_q       <= pend_d;
            pend_ovf_q   <= pend_ovf_d;
            pend_valid_q <= pend_valid_d;
            disp_q       <= disp_d;
            disp_ovf_q   <= disp_ovf_d;
        end
    end

    assign busy_out     = (state_q != StIdle);
    assign overflow_out = disp_ovf_q;

    // Stage 1: position relative to the overlay origin.
    logic signed [11:0] dx, dy;
    logic [31:0]        dx32;
    logic               s1_inside_d, s1_inside_q, s1_gap_d, s1_gap_q;
    logic [2:0]         s1_cell_d, s1_cell_q;
    logic [11:0]        s1_lx_d, s1_lx_q, s1_ly_q;

    always_comb begin
        dx          = $signed({1'b0, hcount_in}) - $signed({1'b0, x_in});
        dy          = $signed({2'b00, vcount_in}) - $signed({2'b00, y_in});
        dx32        = {21'd0, dx[10:0]};
        s1_inside_d = !dx[11] && !dy[11] && ({21'd0, dy[10:0]} < DIGIT_H) && (dx32 < SPAN);
        s1_cell_d   = 3'(dx32 / PITCH);
        s1_lx_d     = 12'(dx32 % PITCH);
        s1_gap_d    = (dx32 % PITCH) >= DIGIT_W;
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            s1_inside_q <= 1'b0;
            s1_gap_q    <= 1'b0;
            s1_cell_q   <= '0;
            s1_lx_q     <= '0;
            s1_ly_q     <= '0;
        end else begin
            s1_inside_q <= s1_inside_d;
            s1_gap_q    <= s1_gap_d;
            s1_cell_q   <= s1_cell_d;
            s1_lx_q     <= s1_lx_d;
            s1_ly_q     <= dy;
        end
    end

    // Stage 2: segment hit test against the committed digits.
    logic [31:0]           lx32, ly32;
    logic [6:0]            region, seg_map;
    logic [3:0]            digit;
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  run_zero, cell_blank, pix_on, top;

    always_comb begin
        lx32   = {20'd0, s1_lx_q};
        ly32   = {20'd0, s1_ly_q};
        top    = ly32 < DIGIT_H / 2;
        // Bit order {a, b, c, d, e, f, g}.
        region = {ly32 < SEG_T,
                  (lx32 >= DIGIT_W - SEG_T) && top,
                  (lx32 >= DIGIT_W - SEG_T) && !top,
                  ly32 >= DIGIT_H - SEG_T,
                  (lx32 < SEG_T) && !top,
                  (lx32 < SEG_T) && top,
                  (ly32 + SEG_T / 2 + 1 > DIGIT_H / 2) && (ly32 < DIGIT_H / 2 + SEG_T / 2 + 1)};

        run_zero  = 1'b1;
        lead_zero = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            run_zero     = run_zero && (disp_q[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
            lead_zero[i] = run_zero;
        end

        digit      = '0;
        cell_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (s1_cell_q == 3'(i)) begin
                digit      = disp_q[4*(NUM_DIGITS-1-i) +: 4];
                cell_blank = BLANK_LZ && lead_zero[i] && (i != NUM_DIGITS - 1);
            end
        end

        case (digit)
            4'd0:    seg_map = 7'b1111110;
            4'd1:    seg_map = 7'b0110000;
            4'd2:    seg_map = 7'b1101101;
            4'd3:    seg_map = 7'b1111001;
            4'd4:    seg_map = 7'b0110011;
            4'd5:    seg_map = 7'b1011011;
            4'd6:    seg_map = 7'b1011111;
            4'd7:    seg_map = 7'b1110000;
            4'd8:    seg_map = 7'b1111111;
            4'd9:    seg_map = 7'b1111011;
            default: seg_map = 7'b0000000;
        endcase

        if (disp_ovf_q) begin
            pix_on = region[0];
        end else begin
            pix_on = |(region & seg_map) && !cell_blank;
        end
        pix_on = pix_on && s1_inside_q && !s1_gap_q;
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            red_out   <= '0;
            green_out <= '0;
            blue_out  <= '0;
        end else begin
            red_out   <= pix_on ? COLOR[23:16] : 8'd0;
            green_out <= pix_on ? COLOR[15:8]  : 8'd0;
            blue_out  <= pix_on ? COLOR[7:0]   : 8'd0;
        end
    end

endmodule

// File: tb/tb_number_overlay.sv
// Randomised bench for number_overlay: each scenario task checks the DUT against a
// model that draws digits straight from the decimal value and segment geometry.
module tb_number_overlay;

    localparam int ND = 4, CW = 32, CH = 48, CG = 8, ST = 3, PITCH = CW + CG;
    localparam logic [23:0] LIT = 24'hFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] x_in = '0, hcount = '0;
    logic [9:0]  y_in = '0, vcount = '0;
    logic [13:0] value = '0;
    logic        value_valid = 1'b0, frame_start = 1'b0;
    logic [7:0]  red, green, blue;
    logic        busy, overflow;

    int total = 0;
    int bad = 0;
    int exp_val = 0;
    bit exp_ovf = 1'b0;
    int xo = 100, yo = 50;

    string segmap[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                          "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    always #5 clk = ~clk;

    number_overlay dut (
        .pixel_clk_in  (clk),
        .rst_in        (rst),
        .x_in          (x_in),
        .y_in          (y_in),
        .hcount_in     (hcount),
        .vcount_in     (vcount),
        .value_in      (value),
        .value_valid_in(value_valid),
        .frame_start_in(frame_start),
        .red_out       (red),
        .green_out     (green),
        .blue_out      (blue),
        .busy_out      (busy),
        .overflow_out  (overflow)
    );

    function automatic bit has_seg(string s, byte c);
        for (int i = 0; i < s.len(); i++) if (s[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [23:0] model_rgb(int val, bit ovf, int h, int v, int x, int y);
        int dx = h - x;
        int dy = v - y;
        int lx, ly, k, p10, d;
        bit a, b, c, dd, e, f, g, lit;
        string m;
        if (dx < 0 || dy < 0 || dy >= CH || dx >= ND * PITCH) return 24'h0;
        lx = dx % PITCH;
        ly = dy;
        if (lx >= CW) return 24'h0;
        k = ND - 1 - dx / PITCH;
        p10 = 1;
        for (int i = 0; i < k; i++) p10 *= 10;
        d  = (val / p10) % 10;
        a  = ly < ST;
        dd = ly >= CH - ST;
        g  = (ly - CH / 2 < ST / 2 + 1) && (CH / 2 - ly < ST / 2 + 1);
        f  = lx < ST && ly < CH / 2;
        e  = lx < ST && ly >= CH / 2;
        b  = lx >= CW - ST && ly < CH / 2;
        c  = lx >= CW - ST && ly >= CH / 2;
        if (ovf) begin
            lit = g;
        end else if (k > 0 && val < p10) begin
            lit = 1'b0;
        end else begin
            m = segmap[d];
            lit = (a && has_seg(m, "a")) || (b && has_seg(m, "b")) || (c && has_seg(m, "c")) ||
                  (dd && has_seg(m, "d")) || (e && has_seg(m, "e")) || (f && has_seg(m, "f")) ||
                  (g && has_seg(m, "g"));
        end
        return lit ? LIT : 24'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(int val);
        value = 14'(val);
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s wait_idle: busy=%b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic check_pixel(int h, int v, string name);
        logic [23:0] want;
        hcount = 11'(h);
        vcount = 10'(v);
        tick();
        tick();
        want = model_rgb(exp_val, exp_ovf, h, v, xo, yo);
        total++;
        if ({red, green, blue} !== want) begin
            bad++;
            $display("FAIL %s pixel(%0d,%0d): got %h required %h", name, h, v,
                     {red, green, blue}, want);
        end
    endtask

    task automatic scan_random(int n, string name);
        for (int i = 0; i < n; i++) begin
            check_pixel(xo - 5 + $urandom_range(0, ND * PITCH + 10),
                        yo - 5 + $urandom_range(0, CH + 10), name);
        end
    endtask

    task automatic check_bit(logic got, logic want, string name);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b required %b", name, got, want);
        end
    endtask

    task automatic test_reset();
        x_in = 11'(xo);
        y_in = 10'(yo);
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({red, green, blue} !== 24'h0) begin
            bad++;
            $display("FAIL reset_rgb: got %h required 000000", {red, green, blue});
        end
        check_bit(busy, 1'b0, "reset_busy");
        check_bit(overflow, 1'b0, "reset_overflow");
        rst = 1'b0;
        tick();
        exp_val = 0;
        exp_ovf = 1'b0;
        frame();
        check_pixel(xo + 3 * PITCH + 10, yo + 1, "reset_right_a");
        check_pixel(xo + 10, yo + 1, "reset_left_blank");
        check_pixel(xo + 3 * PITCH + 1, yo + 30, "reset_right_e");
        scan_random(40, "reset_scan");
        check_bit(busy, 1'b0, "reset_busy_after_scan");
    endtask

    task automatic test_convert();
        int cnt = 0;
        value = 14'd1234;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (busy) cnt++;
            tick();
        end
        total++;
        if (cnt != 15) begin
            bad++;
            $display("FAIL convert_busy_len: got %0d cycles required 15", cnt);
        end
        check_pixel(xo + 3 * PITCH + 10, yo + 1, "convert_before_commit");
        frame();
        exp_val = 1234;
        check_bit(overflow, 1'b0, "convert_overflow");
        check_pixel(xo + 1, yo + 1, "convert_corner");
        // Latency: a lit pixel must appear on the second edge, not the first.
        hcount = 11'(xo - 3);
        tick();
        tick();
        hcount = 11'(xo + 30);
        vcount = 10'(yo + 10);
        tick();
        total++;
        if ({red, green, blue} !== 24'h0) begin
            bad++;
            $display("FAIL latency_early: got %h required 000000", {red, green, blue});
        end
        tick();
        total++;
        if ({red, green, blue} !== model_rgb(exp_val, exp_ovf, xo + 30, yo + 10, xo, yo)) begin
            bad++;
            $display("FAIL latency_two: got %h required %h", {red, green, blue},
                     model_rgb(exp_val, exp_ovf, xo + 30, yo + 10, xo, yo));
        end
        scan_random(60, "convert_scan");
    endtask

    task automatic test_overflow();
        strobe(12000);
        wait_idle("overflow");
        check_bit(overflow, 1'b0, "overflow_before_commit");
        frame();
        exp_val = 12000;
        exp_ovf = 1'b1;
        check_bit(overflow, 1'b1, "overflow_after_commit");
        for (int i = 0; i < ND; i++) begin
            check_pixel(xo + i * PITCH + 15, yo + CH / 2, "overflow_g");
            check_pixel(xo + i * PITCH + 1, yo + 10, "overflow_f");
        end
        scan_random(40, "overflow_scan");
    endtask

    task automatic test_hold();
        int cnt = 0;
        value = 14'd5;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        if (busy) cnt++;
        for (int c = 1; c < 60; c++) begin
            if (c == 3) begin
                value = 14'd7;
                value_valid = 1'b1;
            end else if (c == 6) begin
                value = 14'd9;
                value_valid = 1'b1;
            end else begin
                value_valid = 1'b0;
            end
            tick();
            if (busy) cnt++;
        end
        value_valid = 1'b0;
        total++;
        if (cnt != 30) begin
            bad++;
            $display("FAIL hold_busy_total: got %0d cycles required 30", cnt);
        end
        frame();
        exp_val = 9;
        exp_ovf = 1'b0;
        check_bit(overflow, 1'b0, "hold_overflow_clear");
        check_pixel(xo + 3 * PITCH + 30, yo + 10, "hold_b");
        check_pixel(xo + 3 * PITCH + 15, yo + CH - 2, "hold_d");
        for (int i = 0; i < ND - 1; i++) check_pixel(xo + i * PITCH + 15, yo + CH / 2, "hold_lz");
        scan_random(40, "hold_scan");
    endtask

    task automatic test_coincide();
        value = 14'd42;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        repeat (14) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check_bit(busy, 1'b0, "coincide_idle");
        check_pixel(xo + 2 * PITCH + 1, yo + 10, "coincide_tens_held");
        check_pixel(xo + 3 * PITCH + 1, yo + 30, "coincide_ones_held");
        frame();
        exp_val = 42;
        check_pixel(xo + 2 * PITCH + 1, yo + 10, "coincide_tens_new");
        check_pixel(xo + 3 * PITCH + 1, yo + 30, "coincide_ones_new");
        scan_random(30, "coincide_scan");
    endtask

    task automatic test_reset_mid();
        strobe(777);
        repeat (5) tick();
        check_bit(busy, 1'b1, "midreset_busy_before");
        rst = 1'b1;
        value = 14'd55;
        value_valid = 1'b1;
        tick();
        rst = 1'b0;
        value_valid = 1'b0;
        exp_val = 0;
        exp_ovf = 1'b0;
        check_bit(busy, 1'b0, "midreset_busy_next");
        tick();
        check_bit(busy, 1'b0, "midreset_no_accept");
        repeat (20) tick();
        frame();
        check_bit(overflow, 1'b0, "midreset_overflow");
        check_pixel(xo + 3 * PITCH + 10, yo + 1, "midreset_a");
        check_pixel(xo + 3 * PITCH + 1, yo + 30, "midreset_e");
        check_pixel(xo + 2 * PITCH + 30, yo + 10, "midreset_tens");
        scan_random(30, "midreset_scan");
    endtask

    task automatic test_random();
        int v;
        for (int n = 0; n < 4; n++) begin
            xo = $urandom_range(5, 1800);
            yo = $urandom_range(5, 900);
            x_in = 11'(xo);
            y_in = 10'(yo);
            v = $urandom_range(0, 16383) >> $urandom_range(0, 12);
            strobe(v);
            wait_idle("random");
            frame();
            exp_val = v;
            exp_ovf = (v > 9999);
            check_bit(overflow, exp_ovf, "random_overflow");
            scan_random(40, "random_scan");
        end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_overflow();
        test_hold();
        test_coincide();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/number_overlay.md
NUMBER_OVERLAY -- requirements
Module: number_overlay

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4: number of decimal digit cells, 1..8.
REQ-002 The block SHALL have parameter VALUE_W, default 14: width of the unsigned binary input value.
REQ-003 The block SHALL have parameter DIGIT_W, default 32: glyph cell width in pixels.
REQ-004 The block SHALL have parameter DIGIT_H, default 48: glyph cell height in pixels; it SHALL be even.
REQ-005 The block SHALL have parameter GAP, default 8: blank pixels between adjacent cells.
REQ-006 The block SHALL have parameter SEG_T, default 3: segment thickness in pixels.
REQ-007 The block SHALL have parameter COLOR, default 24'hFFFFFF: lit RGB colour, R in bits [23:16].
REQ-008 The block SHALL have parameter BLANK_LZ, default 1: 1 means leading-zero blanking is enabled.
REQ-009 The block SHALL have port pixel_clk_in, input, 1 bit: the single clock for all logic.
REQ-010 The block SHALL have port rst_in, input, 1 bit: synchronous active-high reset.
REQ-011 The block SHALL have ports x_in [10:0] and y_in [9:0], inputs: top-left corner of the leftmost cell.
REQ-012 The block SHALL have ports hcount_in [10:0] and vcount_in [9:0], inputs: current pixel position.
REQ-013 The block SHALL have port value_in [VALUE_W-1:0], input: unsigned value to display.
REQ-014 The block SHALL have port value_valid_in, input, 1 bit: single-cycle strobe that offers value_in.
REQ-015 The block SHALL have port frame_start_in, input, 1 bit: single-cycle strobe marking the start of a frame.
REQ-016 The block SHALL have ports red_out, green_out and blue_out, outputs, 8 bits each: registered pixel colour.
REQ-017 The block SHALL have port busy_out, output, 1 bit: high while a conversion is in progress.
REQ-018 The block SHALL have port overflow_out, output, 1 bit: high while the displayed value exceeds 10^NUM_DIGITS-1.

Function
REQ-019 Conversion FSM states SHALL be IDLE, SHIFT and DONE, with binary-to-BCD conversion by shift-and-add-3 (double dabble).
REQ-020 In IDLE, when value_valid_in=1, the block SHALL latch value_in and enter SHIFT, with busy_out=1 from the next cycle.
REQ-021 SHIFT SHALL last exactly VALUE_W cycles, one bit per cycle; DONE SHALL last 1 cycle, write the result to the pending register, set pending_valid and return to IDLE.
REQ-022 A value_valid_in arriving while not in IDLE SHALL go to a one-deep hold register (latest wins); a held value SHALL start the cycle after DONE.
REQ-023 When the converted value exceeds 10^NUM_DIGITS-1, the pending register SHALL mark overflow, which displays segment g only in every cell.
REQ-024 At frame_start_in with pending_valid=1 at cycle start, the block SHALL copy pending to the display register and clear pending_valid; if DONE coincides with frame_start_in, the commit SHALL wait for the next frame_start_in.
REQ-025 overflow_out SHALL update only on display commit.
REQ-026 Pixel pipeline latency SHALL be 2 cycles: hcount_in/vcount_in sampled at cycle N produce colour at cycle N+2.
REQ-027 Stage 1 SHALL compute dx=hcount_in-x_in and dy=vcount_in-y_in with 12-bit signed arithmetic; a pixel is outside when dx<0, dy<0, dy>=DIGIT_H or dx>=NUM_DIGITS*(DIGIT_W+GAP).
REQ-028 Stage 1 SHALL register the cell index (dx/(DIGIT_W+GAP), where cell 0 is the most significant digit), lx, ly and an in-gap flag (lx>=DIGIT_W).
REQ-029 Segment regions SHALL be: a: ly<SEG_T; d: ly>=DIGIT_H-SEG_T; g: |ly-DIGIT_H/2|<SEG_T/2+1; f: lx<SEG_T and ly<DIGIT_H/2; e: lx<SEG_T and ly>=DIGIT_H/2; b: lx>=DIGIT_W-SEG_T and ly<DIGIT_H/2; c: lx>=DIGIT_W-SEG_T and ly>=DIGIT_H/2.
REQ-030 Digit segment maps SHALL be: 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg.
REQ-031 With BLANK_LZ=1, zero cells left of the most significant nonzero digit SHALL be dark; the rightmost cell SHALL always be shown.
REQ-032 Stage 2 SHALL output COLOR when the pixel is inside, not in a gap and on a lit segment, and 0 otherwise.

Reset
REQ-033 On rst_in=1 at a clock edge, FSM=IDLE, hold, pending and display registers (display value 0), pending_valid, busy_out, overflow_out and all colour outputs and pipeline registers SHALL be 0.
REQ-034 Reset during SHIFT SHALL abort the conversion with no commit; no value_valid_in is accepted in the reset cycle.

Verification
REQ-035 Reset, then scan a frame -> only the rightmost cell shows "0" (abcdef), other cells dark, busy_out=0.
REQ-036 value_in=1234 with strobe -> busy_out high 15 cycles; after next frame_start_in, cells read "1234"; pixel (x_in+1, y_in+1) gives COLOR 2 cycles later.
REQ-037 value_in=12000 (NUM_DIGITS=4) -> after commit overflow_out=1, all four cells show g only.
REQ-038 Strobes of 5, 7 and 9 spaced 3 cycles apart -> 5 converts, 9 converts next (7 dropped); display shows "9" with 3 blank leading cells.
REQ-039 DONE coincident with frame_start_in -> display unchanged this frame, updated at the following frame_start_in.
REQ-040 rst_in asserted mid-SHIFT -> busy_out=0 next cycle, display holds 0, no commit on later frame_start_in.
